// File: rtl/dff_tb_pkg.sv
// Shared types and constants for the DFF stimulus/signature block:
// FSM state encoding, stimulus LFSR taps and MISR polynomial/seed.
package dff_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/dff_misr.sv
// 32-bit multiple-input signature register compressing folded DFF responses.
module dff_misr
  import dff_tb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] fold,
  output logic [31:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_INIT;
    end else if (clear) begin
      sig <= MISR_INIT;
    end else if (en) begin
      sig <= {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ fold;
    end
  end

endmodule

// File: rtl/dff_stim_sig.sv
// LFSR stimulus generator and response signature for a DFF array under test.
// Optional MSB-first serial readout of sig is built when DFF_SIG_SERIAL_EN is defined.
module dff_stim_sig
  import dff_tb_pkg::*;
#(
  parameter int          N_VECTORS = 256,
  parameter int          HOLD      = 4,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          Q_W       = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           d,
  output logic           en,
  output logic           sr,
  input  logic [Q_W-1:0] q,
  output logic           busy,
  output logic           done,
  output logic [31:0]    sig,
  output logic           sig_valid,
  output logic           ser_out,
  output logic           ser_valid
);

  localparam logic [3:0]  HOLD_LAST = 4'(HOLD - 1);
  localparam logic [15:0] VEC_LAST  = 16'(N_VECTORS - 1);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [3:0]  hold_cnt;
  logic [15:0] vec_cnt;
  logic [31:0] fold;
  logic        run_start;
  logic        sample;
  logic        fin;

  assign run_start = (state != ST_RUN) && start;
  assign sample    = (state == ST_RUN) && (hold_cnt == HOLD_LAST);
  assign fin       = sample && (vec_cnt == VEC_LAST);

  assign busy = (state == ST_RUN);
  assign d    = busy & lfsr[0];
  assign en   = busy & lfsr[1];
  assign sr   = busy & lfsr[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (fin)   state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  // One LFSR step per vector, taken on the sampling cycle so the next vector follows directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= SEED;
      hold_cnt <= 4'd0;
      vec_cnt  <= 16'd0;
    end else if (run_start) begin
      lfsr     <= SEED;
      hold_cnt <= 4'd0;
      vec_cnt  <= 16'd0;
    end else if (state == ST_RUN) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_cnt <= 4'd0;
        vec_cnt  <= vec_cnt + 16'd1;
        lfsr     <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
      end else begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      sig_valid <= 1'b0;
    end else begin
      done <= fin;
      if (run_start)  sig_valid <= 1'b0;
      else if (fin)   sig_valid <= 1'b1;
    end
  end

  always_comb begin
    fold = 32'h0;
    for (int i = 0; i < Q_W / 32; i++) begin
      fold = fold ^ q[i*32 +: 32];
    end
  end

  dff_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (run_start),
    .en    (sample),
    .fold  (fold),
    .sig   (sig)
  );

`ifdef DFF_SIG_SERIAL_EN
  logic [31:0] ser_shift;
  logic [4:0]  ser_cnt;
  logic        ser_act;

  // Shift starts the cycle after done; a start request (including one during done) cancels it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_shift <= 32'h0;
      ser_cnt   <= 5'd0;
      ser_act   <= 1'b0;
    end else if (start) begin
      ser_act <= 1'b0;
    end else if (done) begin
      ser_shift <= sig;
      ser_cnt   <= 5'd31;
      ser_act   <= 1'b1;
    end else if (ser_act) begin
      if (ser_cnt == 5'd0) begin
        ser_act <= 1'b0;
      end else begin
        ser_shift <= {ser_shift[30:0], 1'b0};
        ser_cnt   <= ser_cnt - 5'd1;
      end
    end
  end

  assign ser_out   = ser_act & ser_shift[31];
  assign ser_valid = ser_act;
`else
  assign ser_out   = 1'b0;
  assign ser_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dff_stim_sig.sv
// Self-checking bench for dff_stim_sig: cycle table on a one-vector instance,
// randomized full runs on a default instance against a behavioural LFSR/MISR model.
module tb_dff_stim_sig;

  localparam int NV = 256;
  localparam int HB = 4;
  localparam logic [15:0] SEED_V = 16'hACE1;
  localparam logic [31:0] POLY   = 32'h04C11DB7;
  localparam logic [31:0] INIT   = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b;
  logic [63:0] q_a, q_b;
  logic        d_a, en_a, sr_a, busy_a, done_a, sig_valid_a, ser_out_a, ser_valid_a;
  logic        d_b, en_b, sr_b, busy_b, done_b, sig_valid_b, ser_out_b, ser_valid_b;
  logic [31:0] sig_a, sig_b;

  int errors = 0;
  int checks = 0;

  logic [63:0] samp [NV];

  always #5 clk = ~clk;

  dff_stim_sig #(.N_VECTORS(1), .HOLD(4), .SEED(SEED_V), .Q_W(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .d(d_a), .en(en_a), .sr(sr_a),
    .q(q_a), .busy(busy_a), .done(done_a), .sig(sig_a), .sig_valid(sig_valid_a),
    .ser_out(ser_out_a), .ser_valid(ser_valid_a)
  );

  dff_stim_sig #(.N_VECTORS(NV), .HOLD(HB), .SEED(SEED_V), .Q_W(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .d(d_b), .en(en_b), .sr(sr_b),
    .q(q_b), .busy(busy_b), .done(done_b), .sig(sig_b), .sig_valid(sig_valid_b),
    .ser_out(ser_out_b), .ser_valid(ser_valid_b)
  );

  typedef struct {
    logic        start;
    logic [63:0] q;
    logic [2:0]  stim;
    logic        busy;
    logic        done;
    logic        sig_valid;
    logic        chk_sig;
    logic [31:0] sig;
  } row_t;

  row_t tbl [13];

  function automatic row_t mk_row(input logic s, input logic [63:0] qv, input logic [2:0] st,
                                  input logic b, input logic dn, input logic sv,
                                  input logic cs, input logic [31:0] sg);
    row_t r;
    r.start = s; r.q = qv; r.stim = st; r.busy = b; r.done = dn;
    r.sig_valid = sv; r.chk_sig = cs; r.sig = sg;
    return r;
  endfunction

  // Reference model: spec-level arithmetic for LFSR step, slice fold and signature step
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int unsigned x, fb;
    x  = v;
    fb = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
    return 16'((x >> 1) | (fb << 15));
  endfunction

  function automatic logic [31:0] fold64(input logic [63:0] v);
    return v[31:0] ^ v[63:32];
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input row_t r);
    start_a = r.start;
    q_a     = r.q;
    @(posedge clk);
    #1;
  endtask

  task automatic run_b(input int disturb1, input int disturb2, input int abort_cycle,
                       input int flip_vec, input int flip_bit, input string tag,
                       output logic [31:0] exp_sig);
    logic [63:0] eff [NV];
    logic [15:0] lf;
    logic [31:0] ser_acc;
    int          ser_seen;
    int          done_seen;
    int          last_c;
    int          k;
    for (int i = 0; i < NV; i++) eff[i] = samp[i];
    if (flip_vec >= 0) eff[flip_vec][flip_bit] = ~eff[flip_vec][flip_bit];
    exp_sig = INIT;
    for (int i = 0; i < NV; i++) exp_sig = misr_step(exp_sig, fold64(eff[i]));

    check_output({tag, ".idle_stim"}, {29'd0, sr_b, en_b, d_b}, 32'd0);
    start_b  = 1'b1;
    q_b      = {$urandom, $urandom};
    lf       = SEED_V;
    ser_acc  = 32'h0;
    ser_seen = 0;
`ifdef DFF_SIG_SERIAL_EN
    last_c = NV*HB + 34;
`else
    last_c = NV*HB + 2;
`endif
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_cycle) begin
        rst_n = 1'b0;
        #1;
        check_output({tag, ".abort_busy"}, {31'd0, busy_b}, 32'd0);
        check_output({tag, ".abort_sig"}, sig_b, INIT);
        check_output({tag, ".abort_stim"}, {29'd0, sr_b, en_b, d_b}, 32'd0);
        start_b   = 1'b0;
        done_seen = 0;
        for (int j = 0; j < NV*HB + 4; j++) begin
          @(posedge clk);
          #1;
          if (j == 2) rst_n = 1'b1;
          if (done_b === 1'b1) done_seen++;
        end
        check_output({tag, ".abort_no_done"}, done_seen, 32'd0);
        return;
      end
      start_b = (c == disturb1) || (c == disturb2);
      if (c <= NV*HB) begin
        k = (c - 1) / HB;
        check_output({tag, ".stim"}, {29'd0, sr_b, en_b, d_b}, {29'd0, lf[2], lf[1], lf[0]});
        check_output({tag, ".busy"}, {31'd0, busy_b}, 32'd1);
        check_output({tag, ".done_early"}, {31'd0, done_b}, 32'd0);
        if (c % HB == 0) begin
          q_b = eff[k];
          lf  = lfsr_next(lf);
        end else begin
          q_b = {$urandom, $urandom};
        end
      end else if (c == NV*HB + 1) begin
        q_b = {$urandom, $urandom};
        check_output({tag, ".done"}, {31'd0, done_b}, 32'd1);
        check_output({tag, ".busy_end"}, {31'd0, busy_b}, 32'd0);
        check_output({tag, ".sig_valid"}, {31'd0, sig_valid_b}, 32'd1);
        check_output({tag, ".sig"}, sig_b, exp_sig);
        check_output({tag, ".stim_end"}, {29'd0, sr_b, en_b, d_b}, 32'd0);
      end else begin
        q_b = {$urandom, $urandom};
        if (c == NV*HB + 2) begin
          check_output({tag, ".done_pulse"}, {31'd0, done_b}, 32'd0);
          check_output({tag, ".sig_hold"}, sig_b, exp_sig);
          check_output({tag, ".sig_valid_hold"}, {31'd0, sig_valid_b}, 32'd1);
`ifndef DFF_SIG_SERIAL_EN
          check_output({tag, ".ser_tie"}, {30'd0, ser_valid_b, ser_out_b}, 32'd0);
`endif
        end
        if (ser_valid_b === 1'b1) begin
          ser_seen++;
          ser_acc = {ser_acc[30:0], ser_out_b};
        end
      end
    end
`ifdef DFF_SIG_SERIAL_EN
    check_output({tag, ".ser_len"}, ser_seen, 32'd32);
    check_output({tag, ".ser_data"}, ser_acc, exp_sig);
`endif
  endtask

  initial begin
    logic [31:0] s2, e1, e2, e3, e4, e5;
    logic [63:0] q2;
    rst_n   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    q_a     = 64'h0;
    q_b     = 64'h0;
    #1 rst_n = 1'b0;
    #2;
    check_output("reset.a_outs", {26'd0, d_a, en_a, sr_a, busy_a, done_a, sig_valid_a}, 32'd0);
    check_output("reset.a_sig", sig_a, INIT);
    check_output("reset.b_outs", {24'd0, d_b, en_b, sr_b, busy_b, done_b, sig_valid_b,
                                  ser_out_b, ser_valid_b}, 32'd0);
    check_output("reset.b_sig", sig_b, INIT);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    q2 = 64'h0123_4567_89AB_CDEF;
    s2 = misr_step(INIT, fold64(q2));
    tbl[0]  = mk_row(1'b1, 64'h0,                  3'b000, 0, 0, 0, 1, INIT);
    tbl[1]  = mk_row(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 3'b001, 1, 0, 0, 1, INIT);
    tbl[2]  = mk_row(1'b0, 64'h1111_2222_3333_4444, 3'b001, 1, 0, 0, 0, INIT);
    tbl[3]  = mk_row(1'b0, 64'hFFFF_0000_FFFF_0000, 3'b001, 1, 0, 0, 0, INIT);
    tbl[4]  = mk_row(1'b0, 64'h0,                  3'b001, 1, 0, 0, 0, INIT);
    tbl[5]  = mk_row(1'b1, 64'h0,                  3'b000, 0, 1, 1, 1, 32'hFB3EE249);
    tbl[6]  = mk_row(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 3'b001, 1, 0, 0, 1, INIT);
    tbl[7]  = mk_row(1'b1, 64'h1111_2222_3333_4444, 3'b001, 1, 0, 0, 0, INIT);
    tbl[8]  = mk_row(1'b0, 64'hFFFF_0000_FFFF_0000, 3'b001, 1, 0, 0, 0, INIT);
    tbl[9]  = mk_row(1'b0, q2,                     3'b001, 1, 0, 0, 0, INIT);
    tbl[10] = mk_row(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 3'b000, 0, 1, 1, 1, s2);
    tbl[11] = mk_row(1'b0, 64'h1111_2222_3333_4444, 3'b000, 0, 0, 1, 1, s2);
    tbl[12] = mk_row(1'b0, 64'h0,                  3'b000, 0, 0, 1, 1, s2);

    for (int i = 0; i < 13; i++) begin
      check_output($sformatf("tbl%0d.stim", i), {29'd0, sr_a, en_a, d_a}, {29'd0, tbl[i].stim});
      check_output($sformatf("tbl%0d.busy", i), {31'd0, busy_a}, {31'd0, tbl[i].busy});
      check_output($sformatf("tbl%0d.done", i), {31'd0, done_a}, {31'd0, tbl[i].done});
      check_output($sformatf("tbl%0d.sig_valid", i), {31'd0, sig_valid_a}, {31'd0, tbl[i].sig_valid});
      if (tbl[i].chk_sig) check_output($sformatf("tbl%0d.sig", i), sig_a, tbl[i].sig);
`ifndef DFF_SIG_SERIAL_EN
      check_output($sformatf("tbl%0d.ser", i), {30'd0, ser_valid_a, ser_out_a}, 32'd0);
`endif
      apply_stimulus(tbl[i]);
    end
    start_a = 1'b0;

    for (int i = 0; i < NV; i++) samp[i] = {$urandom, $urandom};
    run_b(-1, -1, -1, -1, 0, "run1", e1);
    run_b(-1, -1, -1, -1, 0, "run2", e2);
    run_b(-1, -1, -1, 17, 40, "flip", e3);
    checks++;
    if (sig_b === e1) begin
      errors++;
      $display("[TB] FAIL flip_changes_sig: got %h, expected a value other than %h", sig_b, e1);
    end
    run_b(50, NV*HB, -1, -1, 0, "disturb", e4);
    run_b(-1, -1, 100, -1, 0, "abort", e5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_stim_sig.md
DFF_STIM_SIG -- requirements
Module: dff_stim_sig

Interface
REQ-001 SHALL have parameter N_VECTORS, default 256, meaning number of stimulus vectors per run (1..65535).
REQ-002 SHALL have parameter HOLD, default 4, meaning cycles each vector is held on d/en/sr (2..15).
REQ-003 SHALL have parameter SEED, default 16'hACE1, meaning stimulus LFSR start value (nonzero).
REQ-004 SHALL have parameter Q_W, default 64, meaning response bus width (multiple of 32).
REQ-005 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: start input 1, run request; d, en, sr outputs 1 each, stimulus to the DFF array under test.
REQ-007 SHALL have ports: q input Q_W, DFF array response; busy output 1; done output 1, one-cycle end pulse.
REQ-008 SHALL have ports: sig output 32, response signature; sig_valid output 1; ser_out output 1; ser_valid output 1.

Function
REQ-009 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after last sample; DONE->RUN on start.
REQ-010 SHALL ignore start while in RUN.
REQ-011 SHALL, on entering RUN, load the LFSR with SEED, sig with 32'hFFFFFFFF, and vector and hold counters with 0.
REQ-012 SHALL use a 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting once per vector.
REQ-013 SHALL drive d=lfsr[0], en=lfsr[1], sr=lfsr[2] in RUN, and drive 0 on all three in IDLE and DONE.
REQ-014 SHALL present vector k during the HOLD cycles k*HOLD+1..(k+1)*HOLD, counted from the start cycle 0.
REQ-015 SHALL sample q on the last hold cycle of each vector.
REQ-016 SHALL fold q as the XOR of all 32-bit slices of q.
REQ-017 SHALL update the signature per sample as sig_next = (sig<<1) ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
REQ-018 SHALL assert busy throughout RUN only.
REQ-019 SHALL pulse done for exactly one cycle, in cycle N_VECTORS*HOLD+1.
REQ-020 SHALL raise sig_valid together with done and hold it until the next RUN entry.
REQ-021 SHALL keep sig constant outside RUN.
REQ-022 SHALL, if start arrives in the cycle done is high, restart RUN next cycle and deassert sig_valid.

Reset
REQ-023 SHALL, on asynchronous reset, set state IDLE, d/en/sr/busy/done/sig_valid/ser_out/ser_valid 0, sig 32'hFFFFFFFF, and LFSR SEED.
REQ-024 SHALL abort any run in progress when reset is asserted mid-RUN, without asserting done.

Configuration
REQ-025 SHALL compile the serial readout only when DFF_SIG_SERIAL_EN is defined.
REQ-026 SHALL, with DFF_SIG_SERIAL_EN defined, shift sig out MSB first on ser_out over the 32 cycles after done, with ser_valid high for those 32 cycles.
REQ-027 SHALL, with DFF_SIG_SERIAL_EN defined, abort the shift if start arrives during it.
REQ-028 SHALL, without DFF_SIG_SERIAL_EN, tie ser_out and ser_valid to 0.

Structure
REQ-029 SHALL place the FSM state enum, the LFSR tap constant, MISR_POLY=32'h04C11DB7 and MISR_INIT=32'hFFFFFFFF in shared package dff_tb_pkg.
REQ-030 SHALL implement the signature register as sub-module dff_misr, with inputs clk, rst_n, clear, en and fold[31:0], and output sig.

Verification
REQ-031 SHALL verify: N_VECTORS=1, HOLD=4, q=0, pulse start -> done in cycle 5, sig=32'hFB3EE249, sig_valid=1.
REQ-032 SHALL verify: default SEED -> first vector d=1, en=0, sr=0 in cycles 1..4; all three are 0 in IDLE.
REQ-033 SHALL verify: start pulsed again during RUN -> done timing and sig unchanged versus the undisturbed run.
REQ-034 SHALL verify: rst_n low in cycle 100 of a default run -> busy=0 and sig=32'hFFFFFFFF immediately, with no done.
REQ-035 SHALL verify: two back-to-back runs with identical q -> identical sig; a single-bit q flip in one sample -> different sig.
REQ-036 SHALL verify, with DFF_SIG_SERIAL_EN defined: 32 ser_out bits after done reassemble to sig, with ser_valid high for exactly 32 cycles.
